// File: rtl/bcd_scan_controller.sv
// -----------------------------------------------------------------------------
// bcd_scan_controller
//
// Purpose:
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   feeding a 4-digit, time-multiplexed, common-anode seven-segment display.
//   A load handshake starts a conversion; the result is committed to bcd_out
//   in one step, so the display never shows a partial result. The scan
//   counter is a clock enable inside the clk_in domain; no derived clock is
//   generated.
//
// Parameters:
//   SCAN_CNTMAX  scan counter terminal value (digit period = SCAN_CNTMAX+1)
//   BIN_W        binary input width (fixed at 14 for 4 BCD digits)
//
// Ports:
//   clk_in   in   1   system clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   bin_in   in   14  binary value, sampled when load is accepted
//   load     in   1   conversion request, accepted only in IDLE
//   busy     out  1   conversion in flight
//   done     out  1   one-cycle pulse when bcd_out has been updated
//   ovf      out  1   last accepted bin_in was > 9999 (shown clamped to 9999)
//   bcd_out  out  16  committed BCD, [15:12] thousands .. [3:0] units
//   sel      out  4   digit enable, active-low one-hot, bit0 = units
//   seg      out  8   segments, active-low, [6:0] = g..a, [7] = dp (off)
//
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant
//                          nonzero digit are blanked (units never blanked).
// -----------------------------------------------------------------------------
module bcd_scan_controller #(
    parameter int SCAN_CNTMAX = 24999,
    parameter int BIN_W       = 14
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [15:0]      bcd_out,
    output logic [3:0]       sel,
    output logic [7:0]       seg
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONVERT = 2'd1;
    localparam logic [1:0] S_COMMIT  = 2'd2;

    localparam int CNT_W = (SCAN_CNTMAX > 0) ? $clog2(SCAN_CNTMAX + 1) : 1;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    // Add 3 to every nibble >= 5 so that the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [15:0] add3(input logic [15:0] acc);
        logic [15:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3
                                                     : acc[i*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;   // dash for non-decimal nibbles
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Conversion FSM
    // -------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [BIN_W-1:0] r_bin;
    logic [15:0]      r_acc;
    logic [3:0]       r_step;
    logic             r_ovf_lat;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [15:0]      r_bcd;

    logic             w_over;
    logic [BIN_W-1:0] w_clamped;

    assign w_over    = (bin_in > BIN_W'(9999));
    assign w_clamped = w_over ? BIN_W'(9999) : bin_in;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_acc     <= '0;
            r_step    <= '0;
            r_ovf_lat <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin     <= w_clamped;
                        r_ovf_lat <= w_over;
                        r_acc     <= '0;
                        r_step    <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    // Adjust then shift {acc, bin} left by one bit.
                    {r_acc, r_bin} <= {add3(r_acc), r_bin} << 1;
                    r_step <= r_step + 4'd1;
                    if (r_step == 4'(BIN_W - 1)) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_bcd   <= r_acc;
                    r_ovf   <= r_ovf_lat;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign ovf     = r_ovf;
    assign bcd_out = r_bcd;

    // -------------------------------------------------------------------------
    // Scan counter and digit index (clock enable, free running)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_W'(SCAN_CNTMAX)) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Digit select / segment decode (registered outputs)
    // -------------------------------------------------------------------------
    logic [3:0] w_nibble;
    logic       w_blank;

    always_comb begin
        w_nibble = r_bcd[3:0];
        case (r_idx)
            2'd0: w_nibble = r_bcd[3:0];
            2'd1: w_nibble = r_bcd[7:4];
            2'd2: w_nibble = r_bcd[11:8];
            2'd3: w_nibble = r_bcd[15:12];
            default: w_nibble = r_bcd[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1: w_blank = (r_bcd[15:4]  == 12'd0);
            2'd2: w_blank = (r_bcd[15:8]  == 8'd0);
            2'd3: w_blank = (r_bcd[15:12] == 4'd0);
            default: w_blank = 1'b0;   // units always shown
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    logic [3:0] r_sel;
    logic [7:0] r_seg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= 4'b1110;
            r_seg <= 8'hC0;
        end else begin
            r_sel <= ~(4'b0001 << r_idx);
            r_seg <= w_blank ? 8'hFF : seg_decode(w_nibble);
        end
    end

    assign sel = r_sel;
    assign seg = r_seg;

endmodule

// File: tb/tb_bcd_scan_controller.sv
module tb_bcd_scan_controller;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b1;
    logic [13:0] bin_in = '0;
    logic        load   = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd_out;
    logic [3:0]  sel;
    logic [7:0]  seg;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_scan_controller #(
        .SCAN_CNTMAX (3),
        .BIN_W       (14)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .bcd_out (bcd_out),
        .sel     (sel),
        .seg     (seg)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion: load for one edge, then sample 40 falling edges.
    task automatic convert(input logic [13:0] v, output int busy_cnt,
                           output int done_cnt, output int overlap);
        busy_cnt = 0;
        done_cnt = 0;
        overlap  = 0;
        @(negedge clk_in);
        bin_in = v;
        load   = 1'b1;
        @(negedge clk_in);
        load   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1 && done === 1'b1) overlap++;
            @(negedge clk_in);
        end
    endtask

    // Align to the start of the units window, then check four digit windows.
    task automatic scan_check(input string tag, input logic [7:0] exp_seg [4]);
        logic [3:0] exp_sel [4];
        logic [3:0] prev;
        bit         found;
        exp_sel[0] = 4'b1110;
        exp_sel[1] = 4'b1101;
        exp_sel[2] = 4'b1011;
        exp_sel[3] = 4'b0111;
        found = 1'b0;
        prev  = sel;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_in);
            if (sel === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            prev = sel;
        end
        chk({tag, "_align"}, {31'd0, found}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_sel%0d", tag, k), {28'd0, sel}, {28'd0, exp_sel[k]});
            chk($sformatf("%s_seg%0d", tag, k), {24'd0, seg}, {24'd0, exp_seg[k]});
            repeat (4) @(negedge clk_in);
        end
    endtask

    initial begin
        int         bc, dc, ov;
        logic [7:0] es [4];

        // Reset from time zero
        #1 rst_n = 1'b0;
        #1;
        chk("rst0_sel",  {28'd0, sel}, 32'hE);
        chk("rst0_seg",  {24'd0, seg}, 32'hC0);
        chk("rst0_bcd",  {16'd0, bcd_out}, 32'h0);
        chk("rst0_busy", {31'd0, busy}, 32'd0);
        chk("rst0_done", {31'd0, done}, 32'd0);
        chk("rst0_ovf",  {31'd0, ovf}, 32'd0);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        // 1234: 15 busy cycles, then one done
        convert(14'd1234, bc, dc, ov);
        chk("c1234_busy_cycles", bc, 15);
        chk("c1234_done_cnt", dc, 1);
        chk("c1234_overlap", ov, 0);
        chk("c1234_bcd", {16'd0, bcd_out}, 32'h1234);
        chk("c1234_ovf", {31'd0, ovf}, 32'd0);

        // Scan through 1234
        es[0] = 8'h99; es[1] = 8'hB0; es[2] = 8'hA4; es[3] = 8'hF9;
        scan_check("scan1234", es);

        // Reset mid-scan
        repeat (2) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk("rst1_sel",  {28'd0, sel}, 32'hE);
        chk("rst1_seg",  {24'd0, seg}, 32'hC0);
        chk("rst1_bcd",  {16'd0, bcd_out}, 32'h0);
        chk("rst1_busy", {31'd0, busy}, 32'd0);
        chk("rst1_done", {31'd0, done}, 32'd0);
        chk("rst1_ovf",  {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;

        // Clamp and overflow, then a normal value clears ovf
        convert(14'd16383, bc, dc, ov);
        chk("c16383_done_cnt", dc, 1);
        chk("c16383_bcd", {16'd0, bcd_out}, 32'h9999);
        chk("c16383_ovf", {31'd0, ovf}, 32'd1);
        convert(14'd42, bc, dc, ov);
        chk("c42_done_cnt", dc, 1);
        chk("c42_bcd", {16'd0, bcd_out}, 32'h0042);
        chk("c42_ovf", {31'd0, ovf}, 32'd0);

        // Boundary: exactly 9999 is not an overflow, 10000 is
        convert(14'd9999, bc, dc, ov);
        chk("c9999_bcd", {16'd0, bcd_out}, 32'h9999);
        chk("c9999_ovf", {31'd0, ovf}, 32'd0);
        convert(14'd10000, bc, dc, ov);
        chk("c10000_bcd", {16'd0, bcd_out}, 32'h9999);
        chk("c10000_ovf", {31'd0, ovf}, 32'd1);

        // Load during conversion is ignored
        dc = 0;
        @(negedge clk_in);
        bin_in = 14'd5678;
        load   = 1'b1;
        @(negedge clk_in);          // after E0
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) begin       // sampled at E5
                bin_in = 14'd1111;
                load   = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (done === 1'b1) dc++;
            @(negedge clk_in);
        end
        chk("ign_done_cnt", dc, 1);
        chk("ign_bcd", {16'd0, bcd_out}, 32'h5678);

        // Reset mid-conversion aborts it
        @(negedge clk_in);
        bin_in = 14'd321;
        load   = 1'b1;
        @(negedge clk_in);
        load = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bcd", {16'd0, bcd_out}, 32'h0);
        @(negedge clk_in);
        rst_n = 1'b1;
        dc = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) dc++;
            @(negedge clk_in);
        end
        chk("abort_no_done", dc, 0);
        chk("abort_bcd_hold", {16'd0, bcd_out}, 32'h0);

        // Leading-zero handling for value 7
        convert(14'd7, bc, dc, ov);
        chk("c7_bcd", {16'd0, bcd_out}, 32'h0007);
`ifdef LEADING_ZERO_BLANK_EN
        es[0] = 8'hF8; es[1] = 8'hFF; es[2] = 8'hFF; es[3] = 8'hFF;
`else
        es[0] = 8'hF8; es[1] = 8'hC0; es[2] = 8'hC0; es[3] = 8'hC0;
`endif
        scan_check("scan7", es);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_scan_controller.md
# bcd_scan_controller

Sequential binary-to-BCD converter plus 4-digit seven-segment scan controller for the binary2bcd display path. Accepts a 14-bit binary value on a load handshake and converts it with a 14-step shift-and-add-3 sequence. It then drives a time-multiplexed common-anode display from an internal divided scan tick. The scan counter runs in the `clk_in` domain as a clock enable and generates no derived clock.

## Interface
Parameters:
- `SCAN_CNTMAX`, 24999: scan counter terminal value; one digit period = `SCAN_CNTMAX`+1 clocks.
- `BIN_W`, 14: binary input width; fixed at 14 for 4 BCD digits.

Ports:
- `clk_in`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bin_in`  in  14  binary value; sampled only when `load` is accepted.
- `load`  in  1  conversion request; accepted only in IDLE.
- `busy`  out  1  high while a conversion is in flight.
- `done`  out  1  one-cycle pulse when `bcd_out` has been updated.
- `ovf`  out  1  set when the last accepted `bin_in` was >9999; updated at commit.
- `bcd_out`  out  16  committed BCD: [15:12] thousands … [3:0] units.
- `sel`  out  4  digit enable, active-low one-hot; bit0 = units.
- `seg`  out  8  segments, active-low; [6:0]=g..a, [7]=dp (always 1).

## Operation
- FSM states and transitions:
  - IDLE: `load`=1 latches min(`bin_in`, 9999) into the shift register, latches the overflow flag, clears the BCD accumulator and goes to CONVERT.
  - CONVERT: 14 cycles. Each cycle adds 3 to every accumulator nibble ≥5, then shifts {acc, bin} left by 1. After the 14th shift it goes to COMMIT.
  - COMMIT: copies the accumulator to `bcd_out`, copies the latched flag to `ovf`, pulses `done` and returns to IDLE.
- `load` is ignored outside IDLE; there is no queuing. `load` held high re-triggers on every IDLE cycle.
- `bcd_out` holds its value between commits, so the display never shows partial results.
- Scan counter: counts 0..`SCAN_CNTMAX`, then wraps to 0 and advances the digit index 0→1→2→3→0.
- `sel` = ~(1<<index).
- `seg` decodes `bcd_out` nibble[index]: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90. Any nibble >9 shows BF (dash).
- Scan runs continuously and independently of the FSM; a commit changes `seg` in the next cycle.

## Timing
- Reset values (async assert): state IDLE, `busy`=0, `done`=0, `ovf`=0, `bcd_out`=0, scan counter 0, index 0, `sel`=4'b1110, `seg`=8'hC0.
- Conversion latency: `load` sampled at edge E0. `busy`=1 after E0. CONVERT covers E1–E14 and COMMIT is entered at E14. At E15 `bcd_out` and `ovf` update, `done`=1 for one cycle and `busy`=0. Total latency is 15 edges, load to done.
- `done` and `busy` are never high together.
- A new `load` is accepted at E15+1 at the earliest.
- `seg`/`sel` are registered: they change one cycle after counter wrap or after a `bcd_out` change.
- Reset mid-conversion aborts the conversion: no `done`, `bcd_out` returns to 0.
- Deassertion of `rst_n` is synchronised externally; the block assumes clean release.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: any digit above the most-significant nonzero digit shows `seg`=8'hFF. Units is never blanked, so value 0 shows a single "0".
- `LEADING_ZERO_BLANK_EN` undefined: all four digits always display, including leading zeros.

## Test plan
- Reset: hold `rst_n`=0 mid-scan → `sel`=1110, `seg`=C0, `bcd_out`=0, `busy`/`done`/`ovf`=0.
- `bin_in`=1234, `load` pulse → `busy` high 15 cycles, then `done` one cycle with `bcd_out`=16'h1234 and `ovf`=0.
- `bin_in`=16383 → `bcd_out`=16'h9999, `ovf`=1. A following conversion of 42 gives `bcd_out`=16'h0042 and `ovf`=0.
- `load` with 5678 at E0, then `load` with 1111 at E5 → only one `done`, `bcd_out`=16'h5678.
- `SCAN_CNTMAX`=3, `bcd_out`=16'h1234 → `sel` steps 1110/1101/1011/0111 every 4 clocks with `seg` 99/B0/A4/F9.
- With `LEADING_ZERO_BLANK_EN`, `bin_in`=7 → digits 3..1 `seg`=FF, units F8. Without the macro → C0,C0,C0,F8.
